// File: rtl/rc_filter_pkg.sv
// Shared definitions for the raised-cosine TX filter sequencer and its helpers.
// Holds the state encoding, default geometry and counter-width helpers.
package rc_filter_pkg;

    localparam int DEFAULT_OS   = 4;
    localparam int DEFAULT_TAPS = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } seq_state_e;

    function automatic int phaseWidth(input int os);
        return (os > 1) ? $clog2(os) : 1;
    endfunction

    function automatic int countWidth(input int taps);
        return $clog2(taps + 1);
    endfunction

endpackage

// File: rtl/rc_filter_sequencer_tick_gen.sv
// Sample-rate tick divider: one tick every DIV enabled clocks, on the wrap clock itself.
// Shared with the receive-side downsampler.
module sample_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign o_tick = i_enable && (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear || o_tick) begin
            cnt_d = '0;
        end else if (i_enable) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rc_filter_sequencer.sv
// Polyphase raised-cosine TX filter sequencer: sample strobe, phase index, symbol shift
// requests, pipeline fill/drain tracking and underflow reporting.
module rc_filter_sequencer
    import rc_filter_pkg::*;
#(
    parameter int OS   = DEFAULT_OS,
    parameter int TAPS = DEFAULT_TAPS,
    parameter int DIV  = 1
) (
    input  logic                      clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic                      i_start,
    input  logic                      i_stop,
    input  logic                      i_sym_valid,
    output logic                      o_valid,
    output logic [phaseWidth(OS)-1:0] o_phase,
    output logic                      o_sym_req,
    output logic                      o_zero_sel,
    output logic                      o_out_valid,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_underflow
);

    localparam int PW = phaseWidth(OS);
    localparam int CW = countWidth(TAPS);

    seq_state_e    state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [CW-1:0] count_q, count_d;
    logic          stop_q, stop_d;
    logic          under_q, under_d;
    logic          out_valid_q, out_valid_d;
    logic          done_q, done_d;
    logic          busy, start_acc, tick, last_phase, sym_req, src_slot;

    assign busy       = (state_q != IDLE);
    assign start_acc  = !busy && i_enable && i_start;
    assign last_phase = (phase_q == PW'(OS - 1));
    assign sym_req    = tick && last_phase;
    assign src_slot   = (state_q == FILL) || (state_q == RUN);

    sample_tick_gen #(.DIV(DIV)) u_tick (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (i_enable && busy),
        .i_clear  (start_acc),
        .o_tick   (tick)
    );

    // A pending stop beats reaching TAPS in FILL, so a burst stopped early never asserts out_valid.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        count_d     = count_q;
        stop_d      = stop_q;
        under_d     = under_q;
        out_valid_d = out_valid_q;
        done_d      = i_enable ? 1'b0 : done_q;

        if (done_q && i_enable) out_valid_d = 1'b0;
        if (tick) phase_d = last_phase ? '0 : phase_q + PW'(1);
        if (i_enable && i_stop && src_slot) stop_d = 1'b1;
        if (sym_req && src_slot && !i_sym_valid) under_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_d     = FILL;
                    phase_d     = '0;
                    count_d     = '0;
                    stop_d      = 1'b0;
                    under_d     = 1'b0;
                    out_valid_d = 1'b0;
                end
            end
            FILL: begin
                if (sym_req) begin
                    if (stop_q) begin
                        state_d = DRAIN;
                        count_d = '0;
                    end else if (count_q == CW'(TAPS - 1)) begin
                        state_d     = RUN;
                        out_valid_d = 1'b1;
                        count_d     = '0;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            RUN: begin
                if (sym_req && stop_q) begin
                    state_d = DRAIN;
                    count_d = '0;
                end
            end
            DRAIN: begin
                if (sym_req) begin
                    if (count_q == CW'(TAPS - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            count_q     <= '0;
            stop_q      <= 1'b0;
            under_q     <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            count_q     <= count_d;
            stop_q      <= stop_d;
            under_q     <= under_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign o_valid     = tick;
    assign o_phase     = phase_q;
    assign o_sym_req   = sym_req;
    assign o_zero_sel  = sym_req && ((state_q == DRAIN) || !i_sym_valid);
    assign o_out_valid = out_valid_q;
    assign o_busy      = busy;
    assign o_done      = done_q && i_enable;
    assign o_underflow = under_q;

endmodule

// File: tb/tb_rc_filter_sequencer.sv
// Testbench for rc_filter_sequencer: a DIV=1 and a DIV=3 instance share stimulus and are
// compared each clock against a tick/symbol-count reference model.
module tb_rc_filter_sequencer;

    localparam int OS   = 4;
    localparam int TAPS = 6;

    logic clock = 1'b0;
    logic i_reset = 1'b1;
    logic i_enable = 1'b0;
    logic i_start = 1'b0;
    logic i_stop = 1'b0;
    logic i_sym_valid = 1'b0;

    logic       o_valid_a, o_sym_req_a, o_zero_sel_a, o_out_valid_a, o_busy_a, o_done_a, o_underflow_a;
    logic [1:0] o_phase_a;
    logic       o_valid_b, o_sym_req_b, o_zero_sel_b, o_out_valid_b, o_busy_b, o_done_b, o_underflow_b;
    logic [1:0] o_phase_b;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit busy;
        int e;
        int t;
        int lastSym;
        bit under;
        bit outValid;
        bit done;
    } model_t;

    model_t mA, mB;

    rc_filter_sequencer #(.OS(OS), .TAPS(TAPS), .DIV(1)) dut_a (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_start(i_start),
        .i_stop(i_stop), .i_sym_valid(i_sym_valid), .o_valid(o_valid_a), .o_phase(o_phase_a),
        .o_sym_req(o_sym_req_a), .o_zero_sel(o_zero_sel_a), .o_out_valid(o_out_valid_a),
        .o_busy(o_busy_a), .o_done(o_done_a), .o_underflow(o_underflow_a)
    );

    rc_filter_sequencer #(.OS(OS), .TAPS(TAPS), .DIV(3)) dut_b (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_start(i_start),
        .i_stop(i_stop), .i_sym_valid(i_sym_valid), .o_valid(o_valid_b), .o_phase(o_phase_b),
        .o_sym_req(o_sym_req_b), .o_zero_sel(o_zero_sel_b), .o_out_valid(o_out_valid_b),
        .o_busy(o_busy_b), .o_done(o_done_b), .o_underflow(o_underflow_b)
    );

    always #5 clock = ~clock;

    function automatic model_t modelReset();
        model_t m;
        m.busy = 0; m.e = 0; m.t = 0; m.lastSym = -1;
        m.under = 0; m.outValid = 0; m.done = 0;
        return m;
    endfunction

    // e counts enabled busy clocks, t counts ticks; symbol k is shifted on tick 4k+3.
    // lastSym is the final source symbol of a stopped burst; TAPS zero symbols follow it.
    function automatic model_t modelStep(model_t m, int div, bit en, bit start, bit stop, bit symValid);
        model_t n = m;
        bit tick;
        int sym;
        if (!en) return m;
        if (m.done) begin
            n.done = 0;
            n.outValid = 0;
        end
        if (!m.busy) begin
            if (start) begin
                n.busy = 1; n.e = 0; n.t = 0; n.lastSym = -1; n.under = 0; n.outValid = 0;
            end
            return n;
        end
        tick = (m.e % div) == div - 1;
        n.e = m.e + 1;
        if (tick) begin
            n.t = m.t + 1;
            sym = m.t / OS;
            if (m.t % OS == OS - 1) begin
                if (!(m.lastSym >= 0 && sym > m.lastSym) && !symValid) n.under = 1;
                if (sym == TAPS - 1 && m.lastSym < 0) n.outValid = 1;
                if (m.lastSym >= 0 && sym == m.lastSym + TAPS) begin
                    n.busy = 0;
                    n.done = 1;
                end
            end
        end
        if (stop && m.lastSym < 0) n.lastSym = n.t / OS;
        return n;
    endfunction

    function automatic logic [8:0] modelOut(model_t m, int div, bit en, bit symValid);
        bit tick, req, zs;
        int sym;
        tick = m.busy && en && ((m.e % div) == div - 1);
        sym  = m.t / OS;
        req  = tick && (m.t % OS == OS - 1);
        zs   = req && (!symValid || (m.lastSym >= 0 && sym > m.lastSym));
        return {tick, 2'(m.t % OS), req, zs, m.outValid, m.busy, m.done && en, m.under};
    endfunction

    function automatic logic [17:0] actual();
        return {o_valid_a, o_phase_a, o_sym_req_a, o_zero_sel_a, o_out_valid_a, o_busy_a, o_done_a, o_underflow_a,
                o_valid_b, o_phase_b, o_sym_req_b, o_zero_sel_b, o_out_valid_b, o_busy_b, o_done_b, o_underflow_b};
    endfunction

    function automatic logic [17:0] expected();
        return {modelOut(mA, 1, i_enable, i_sym_valid), modelOut(mB, 3, i_enable, i_sym_valid)};
    endfunction

    // Advance one clock from a falling edge, updating the models with this cycle's inputs.
    task automatic nextCycle();
        @(posedge clock);
        if (!i_reset) begin
            mA = modelReset();
            mB = modelReset();
        end else begin
            mA = modelStep(mA, 1, i_enable, i_start, i_stop, i_sym_valid);
            mB = modelStep(mB, 3, i_enable, i_start, i_stop, i_sym_valid);
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        logic [17:0] act;
        #1 i_reset = 1'b0;
        mA = modelReset();
        mB = modelReset();
        @(negedge clock);
        act = actual();
        checks++;
        if (act !== 18'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", act, 18'd0);
        end
        i_reset = 1'b1;
        i_enable = 1'b1;
        i_sym_valid = 1'b1;
        nextCycle();
        #1;
        act = actual();
        checks++;
        if (act !== expected()) begin
            failures++;
            $display("[TB] FAIL idle_after_reset: got %h expected %h", act, expected());
        end
    endtask

    task automatic test_fill_run();
        logic [17:0] act, exv;
        int firstReqA = 0, firstOutA = 0, firstReqB = 0;
        i_start = 1'b1;
        nextCycle();
        i_start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            #1;
            act = actual();
            exv = expected();
            checks++;
            if (act !== exv) begin
                failures++;
                $display("[TB] FAIL fill_run cycle %0d: got %h expected %h", c, act, exv);
            end
            if (o_sym_req_a && firstReqA == 0) firstReqA = c;
            if (o_out_valid_a && firstOutA == 0) firstOutA = c;
            if (o_sym_req_b && firstReqB == 0) firstReqB = c;
            nextCycle();
        end
        checks++;
        if (firstReqA !== 4) begin
            failures++;
            $display("[TB] FAIL first_sym_req_div1: got cycle %0d expected 4", firstReqA);
        end
        // The 6th shift happens in cycle 24; the registered flag shows from cycle 25.
        checks++;
        if (firstOutA !== 25) begin
            failures++;
            $display("[TB] FAIL out_valid_rise: got cycle %0d expected 25", firstOutA);
        end
        checks++;
        if (firstReqB !== 12) begin
            failures++;
            $display("[TB] FAIL first_sym_req_div3: got cycle %0d expected 12", firstReqB);
        end
    endtask

    task automatic test_enable_freeze();
        logic [17:0] act, exv;
        logic [1:0] heldPhase;
        heldPhase = 2'(mA.t % OS);
        i_enable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            act = actual();
            exv = expected();
            checks++;
            if (act !== exv || o_valid_a !== 1'b0 || o_phase_a !== heldPhase) begin
                failures++;
                $display("[TB] FAIL enable_freeze cycle %0d: got %h expected %h", c, act, exv);
            end
            nextCycle();
        end
        i_enable = 1'b1;
        #1;
        checks++;
        if (o_phase_a !== heldPhase || o_valid_a !== 1'b1) begin
            failures++;
            $display("[TB] FAIL enable_resume: got phase %0d valid %b expected phase %0d valid 1",
                     o_phase_a, o_valid_a, heldPhase);
        end
        nextCycle();
    endtask

    task automatic test_underflow();
        logic [17:0] act, exv;
        i_sym_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c == 4) i_sym_valid = 1'b1;
            #1;
            act = actual();
            exv = expected();
            checks++;
            if (act !== exv) begin
                failures++;
                $display("[TB] FAIL underflow cycle %0d: got %h expected %h", c, act, exv);
            end
            nextCycle();
        end
        checks++;
        if (o_underflow_a !== 1'b1) begin
            failures++;
            $display("[TB] FAIL underflow_sticky: got %b expected 1", o_underflow_a);
        end
    endtask

    task automatic test_stop_drain();
        logic [17:0] act, exv;
        int zerosA = 0, donesA = 0, donesB = 0;
        i_stop = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (c == 1) i_stop = 1'b0;
            #1;
            act = actual();
            exv = expected();
            checks++;
            if (act !== exv) begin
                failures++;
                $display("[TB] FAIL stop_drain cycle %0d: got %h expected %h", c, act, exv);
            end
            if (o_sym_req_a && o_zero_sel_a) zerosA++;
            if (o_done_a) donesA++;
            if (o_done_b) donesB++;
            nextCycle();
        end
        checks++;
        if (zerosA !== TAPS || donesA !== 1 || donesB !== 1 || o_busy_a !== 1'b0 || o_busy_b !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drain_summary: got zeros %0d doneA %0d doneB %0d busy %b%b expected zeros 6 doneA 1 doneB 1 busy 00",
                     zerosA, donesA, donesB, o_busy_a, o_busy_b);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [17:0] act, exv;
        int dones = 0;
        i_start = 1'b1;
        nextCycle();
        i_start = 1'b0;
        for (int c = 0; c < 30; c++) nextCycle();
        i_stop = 1'b1;
        nextCycle();
        i_stop = 1'b0;
        for (int c = 0; c < 10; c++) nextCycle();
        #2 i_reset = 1'b0;
        mA = modelReset();
        mB = modelReset();
        #1;
        act = actual();
        checks++;
        if (act !== 18'd0) begin
            failures++;
            $display("[TB] FAIL async_reset_drain: got %h expected %h", act, 18'd0);
        end
        nextCycle();
        i_reset = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            act = actual();
            exv = expected();
            checks++;
            if (act !== exv) begin
                failures++;
                $display("[TB] FAIL after_reset cycle %0d: got %h expected %h", c, act, exv);
            end
            if (o_done_a || o_done_b) dones++;
            nextCycle();
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("[TB] FAIL no_done_after_abort: got %0d pulses expected 0", dones);
        end
    endtask

    task automatic test_random();
        logic [17:0] act, exv;
        for (int c = 0; c < 3000; c++) begin
            i_enable    = ($urandom_range(0, 9) != 0);
            i_start     = ($urandom_range(0, 19) == 0);
            i_stop      = ($urandom_range(0, 59) == 0);
            i_sym_valid = ($urandom_range(0, 15) != 0);
            #1;
            act = actual();
            exv = expected();
            checks++;
            if (act !== exv) begin
                failures++;
                $display("[TB] FAIL random cycle %0d: got %h expected %h", c, act, exv);
            end
            nextCycle();
        end
    endtask

    initial begin
        test_reset();
        test_fill_run();
        test_enable_freeze();
        test_underflow();
        test_stop_drain();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
